sdram_refresh_arbiter: RTL
==========================

// Module: sdram_refresh_arbiter
// PURPOSE
//  Schedules the single SDRAM command port between Zorro II bus accesses and periodic AUTO REFRESH.
//  Sits between the Z2 slave state machine and the SDRAM command sequencer.
//  Tracks owed refreshes in a saturating counter and grants the port to one requester at a time.
//  Forces refresh ahead of new bus accesses when the backlog reaches its limit.
// PARAMETERS
//  REFRESH_INTERVAL  780  MEMCLK cycles between refresh ticks (64ms/4096 rows @ 50MHz)
//  MAX_PENDING       4    backlog depth at which refresh becomes urgent; 1..7
//  T_RFC             7    MEMCLK cycles the port stays busy after a refresh command; >=2
// PORTS
//  MEMCLK       in   1  system/SDRAM clock, all logic on rising edge
//  RESET_n      in   1  asynchronous, active-low reset
//  init_done    in   1  SDRAM power-up init complete; level
//  acc_req      in   1  bus access request from Z2 path; level, held until acc_done
//  acc_done     in   1  one-cycle pulse from SDRAM sequencer, access finished
//  acc_grant    out  1  port owned by bus access
//  ref_cmd      out  1  one-cycle pulse: sequencer issues AUTO REFRESH
//  ref_pending  out  3  owed refreshes, 0..MAX_PENDING
//  ref_overflow out  1  sticky: tick lost while backlog saturated
//  idle         out  1  arbiter in S_IDLE
// BEHAVIOUR
//  Reset (async): state=S_INIT, all outputs 0, interval counter 0. Reset mid-access or mid-refresh aborts at once.
//  Interval counter: runs only while init_done=1. Counts 0..REFRESH_INTERVAL-1 and wraps.
//    - wrap produces tick: ref_pending+1, saturating at MAX_PENDING
//    - tick at saturation sets ref_overflow, cleared only by reset
//  ref_cmd decrements ref_pending in its cycle. Tick and ref_cmd in the same cycle: net unchanged, no overflow.
//  States:
//    S_INIT    -> S_IDLE when init_done=1; acc_req ignored until then
//    S_IDLE    idle=1. Priority, evaluated each cycle:
//                1) ref_pending==MAX_PENDING -> S_REFRESH (urgent, beats acc_req)
//                2) acc_req=1 -> S_ACCESS
//                3) ref_pending>0 -> S_REFRESH
//    S_ACCESS  acc_grant=1 from the cycle after S_IDLE sampled acc_req.
//              Holds until acc_done; acc_grant=0 the cycle after acc_done, then -> S_IDLE.
//              acc_req dropping without acc_done does not release; acc_done outside S_ACCESS ignored.
//    S_REFRESH ref_cmd=1 on entry cycle only. Busy T_RFC cycles total including entry, then -> S_IDLE.
//  Latency: acc_req rising in S_IDLE, no urgent refresh -> acc_grant 1 cycle later.
//    Worst case: one in-flight refresh (T_RFC) plus urgent refresh (T_RFC) plus 1.
//  acc_grant and ref_cmd never both 1. An in-progress access is never preempted.
//  init_done falling after S_INIT: ignored; counter keeps running.
// CONFIGURATION
//  SDRAM_REFRESH_BURST_EN defined:
//    - at end of S_REFRESH with ref_pending>0, go directly to another S_REFRESH
//    - drain to 0 before returning to S_IDLE, even with acc_req=1
//  Not defined:
//    - one refresh per visit; always return to S_IDLE, where priority is re-evaluated
//    - acc_req is served between non-urgent refreshes
// TESTING (REFRESH_INTERVAL=16, MAX_PENDING=4, T_RFC=7 unless stated)
//  Reset then init_done=1, no acc_req -> every 16 cycles: ref_pending 0->1, ref_cmd pulse 1 cycle later, back to 0.
//  acc_req held continuously, acc_done 5 cycles after each grant ->
//    ref_pending climbs to 4; next IDLE goes S_REFRESH before re-granting; ref_overflow stays 0.
//  Hold port in S_ACCESS for 80 cycles with no acc_done ->
//    ref_pending saturates at 4, 5th tick sets ref_overflow=1; it stays 1 after drain.
//  Tick lands in the same cycle as ref_cmd with ref_pending=2 -> ref_pending stays 2.
//  acc_req rises during S_REFRESH, ref_pending=0 -> acc_grant 1 cycle after return to S_IDLE, 7-8 cycles after ref_cmd.
//  SDRAM_REFRESH_BURST_EN, ref_pending=3, acc_req=1 ->
//    3 ref_cmd pulses 7 cycles apart, then acc_grant; RESET_n low mid-burst -> all outputs 0 immediately.

Source files
------------

// File: rtl/sdram_refresh_arbiter.sv
// Arbitrates the SDRAM command port between Zorro II accesses and AUTO REFRESH, tracking owed refreshes.
// Optional macro SDRAM_REFRESH_BURST_EN: drain the whole refresh backlog back-to-back before returning to idle.
module sdram_refresh_arbiter #(
  parameter int REFRESH_INTERVAL = 780,
  parameter int MAX_PENDING      = 4,
  parameter int T_RFC            = 7
) (
  input  logic       MEMCLK,
  input  logic       RESET_n,
  input  logic       init_done,
  input  logic       acc_req,
  input  logic       acc_done,
  output logic       acc_grant,
  output logic       ref_cmd,
  output logic [2:0] ref_pending,
  output logic       ref_overflow,
  output logic       idle
);

  localparam int IW = (REFRESH_INTERVAL > 1) ? $clog2(REFRESH_INTERVAL) : 1;
  localparam int RW = $clog2(T_RFC);
  localparam logic [IW-1:0] INT_LAST = IW'(REFRESH_INTERVAL - 1);
  localparam logic [RW-1:0] RFC_LAST = RW'(T_RFC - 1);
  localparam logic [2:0]    PEND_MAX = 3'(MAX_PENDING);

  typedef enum logic [1:0] {S_INIT, S_IDLE, S_ACCESS, S_REFRESH} state_t;

  state_t        state;
  logic [IW-1:0] int_cnt;
  logic [RW-1:0] rfc_cnt;
  logic          running;
  logic          tick;
  logic          ovf_set;
  logic [2:0]    pend_nxt;

  // Backlog update: a tick and a refresh command in the same cycle cancel out.
  function automatic logic [2:0] pend_update(input logic [2:0] p, input logic inc, input logic dec);
    if (inc && !dec) return (p == PEND_MAX) ? p : p + 3'd1;
    if (dec && !inc) return (p == 3'd0) ? p : p - 3'd1;
    return p;
  endfunction

  always_comb begin
    running  = (state != S_INIT) || init_done;
    tick     = running && (int_cnt == INT_LAST);
    ovf_set  = tick && !ref_cmd && (ref_pending == PEND_MAX);
    pend_nxt = pend_update(ref_pending, tick, ref_cmd);
  end

  always_ff @(posedge MEMCLK or negedge RESET_n) begin
    if (!RESET_n) begin
      int_cnt      <= '0;
      ref_pending  <= 3'd0;
      ref_overflow <= 1'b0;
    end else begin
      if (running) int_cnt <= tick ? '0 : int_cnt + IW'(1);
      ref_pending <= pend_nxt;
      if (ovf_set) ref_overflow <= 1'b1;
    end
  end

  // Port ownership; all outputs registered so the sequencer sees clean levels.
  always_ff @(posedge MEMCLK or negedge RESET_n) begin
    if (!RESET_n) begin
      state     <= S_INIT;
      acc_grant <= 1'b0;
      ref_cmd   <= 1'b0;
      idle      <= 1'b0;
      rfc_cnt   <= '0;
    end else begin
      ref_cmd <= 1'b0;
      case (state)
        S_INIT: begin
          if (init_done) begin
            state <= S_IDLE;
            idle  <= 1'b1;
          end
        end
        S_IDLE: begin
          if ((ref_pending == PEND_MAX) || (!acc_req && ref_pending != 3'd0)) begin
            state   <= S_REFRESH;
            ref_cmd <= 1'b1;
            idle    <= 1'b0;
            rfc_cnt <= '0;
          end else if (acc_req) begin
            state     <= S_ACCESS;
            acc_grant <= 1'b1;
            idle      <= 1'b0;
          end
        end
        S_ACCESS: begin
          if (acc_done) begin
            state     <= S_IDLE;
            acc_grant <= 1'b0;
            idle      <= 1'b1;
          end
        end
        S_REFRESH: begin
          if (rfc_cnt == RFC_LAST) begin
`ifdef SDRAM_REFRESH_BURST_EN
            if (pend_nxt != 3'd0) begin
              ref_cmd <= 1'b1;
              rfc_cnt <= '0;
            end else begin
              state <= S_IDLE;
              idle  <= 1'b1;
            end
`else
            state <= S_IDLE;
            idle  <= 1'b1;
`endif
          end else begin
            rfc_cnt <= rfc_cnt + RW'(1);
          end
        end
        default: begin
          state     <= S_INIT;
          acc_grant <= 1'b0;
          idle      <= 1'b0;
        end
      endcase
    end
  end

endmodule
